// File: rtl/fsk_tx_framer_if.sv
// fsk_tx_framer_if: payload byte handshake between a byte producer and the framer
interface fsk_tx_framer_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   modport master (output data_in, data_valid, input data_ready);
   modport slave (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/fsk_tx_framer.sv
// fsk_tx_framer: frames len payload bytes with preamble/sync/len/CRC-8 and FSK-modulates them
module fsk_tx_framer #(
   parameter int          PREAMBLE_BYTES = 4,
   parameter logic [15:0] SYNC_WORD      = 16'hD391,
   parameter int          BIT_PERIOD     = 16,
   parameter int          F0_HALF        = 4,
   parameter int          F1_HALF        = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [7:0]     len,
   fsk_tx_framer_if.slave dbus,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic           antena_out
);
   localparam int BW = $clog2(BIT_PERIOD + 1);
   localparam int TW = $clog2(F0_HALF + F1_HALF + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(BIT_PERIOD - 1);
   localparam logic [TW-1:0] F0_LAST = TW'(F0_HALF - 1);
   localparam logic [TW-1:0] F1_LAST = TW'(F1_HALF - 1);
   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);

   typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, LEN, PAYLOAD, CRC, END} state_t;

   state_t        state;
   logic [BW-1:0] bit_cnt;
   logic [TW-1:0] tone_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    byte_cnt, len_q, sr, crc, hold, fetched;
   logic          hold_full;
   logic          bit_end, byte_end, tone_hit, fetch;

   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] x;
      x = c ^ d;
      for (int i = 0; i < 8; i++) x = x[7] ? {x[6:0], 1'b0} ^ 8'h07 : {x[6:0], 1'b0};
      return x;
   endfunction

   assign dbus.data_ready = busy & ~hold_full & (fetched < len_q);
   assign fetch = dbus.data_valid & dbus.data_ready;
   assign bit_end = bit_cnt == BIT_LAST;
   assign byte_end = bit_end & (bit_idx == 3'd7);
   assign tone_hit = tone_cnt == (sr[7] ? F1_LAST : F0_LAST);

   // Frame sequencer, bit timer, phase-continuous tone generator and payload holding register
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         tone_cnt   <= '0;
         bit_idx    <= '0;
         byte_cnt   <= '0;
         len_q      <= '0;
         sr         <= '0;
         crc        <= '0;
         hold       <= '0;
         fetched    <= '0;
         hold_full  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         antena_out <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (fetch) begin
            hold      <= dbus.data_in;
            hold_full <= 1'b1;
            fetched   <= fetched + 8'd1;
         end
         if (state == IDLE) begin
            antena_out <= 1'b0;
            if (start) begin
               state     <= PREAMBLE;
               busy      <= 1'b1;
               len_q     <= len;
               sr        <= 8'hAA;
               byte_cnt  <= '0;
               bit_cnt   <= '0;
               tone_cnt  <= '0;
               bit_idx   <= '0;
               fetched   <= '0;
               hold_full <= 1'b0;
               crc       <= '0;
            end
         end else if (state == END) begin
            state <= IDLE;
         end else begin
            antena_out <= antena_out ^ tone_hit;
            tone_cnt   <= (tone_hit | bit_end) ? '0 : tone_cnt + 1'b1;
            bit_cnt    <= bit_end ? '0 : bit_cnt + 1'b1;
            if (bit_end) begin
               bit_idx <= bit_idx + 3'd1;
               sr      <= {sr[6:0], 1'b0};
            end
            if (byte_end) begin
               byte_cnt <= byte_cnt + 8'd1;
               case (state)
                  PREAMBLE:
                     if (byte_cnt == PRE_LAST) begin
                        state    <= SYNC;
                        sr       <= SYNC_WORD[15:8];
                        byte_cnt <= '0;
                     end else sr <= 8'hAA;
                  SYNC:
                     if (byte_cnt == 8'd0) sr <= SYNC_WORD[7:0];
                     else begin
                        state    <= LEN;
                        sr       <= len_q;
                        crc      <= crc8(8'h00, len_q);
                        byte_cnt <= '0;
                     end
                  LEN, PAYLOAD:
                     if (byte_cnt == len_q) begin
                        state <= CRC;
                        sr    <= crc;
                     end else if (hold_full) begin
                        state     <= PAYLOAD;
                        sr        <= hold;
                        hold_full <= 1'b0;
                        crc       <= crc8(crc, hold);
                     end else begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        err        <= 1'b1;
                        antena_out <= 1'b0;
                     end
                  default: begin
                     state      <= END;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     antena_out <= 1'b0;
                  end
               endcase
            end
         end
      end
endmodule

// File: doc/fsk_tx_framer.md
FSK_TX_FRAMER -- requirements
Module: fsk_tx_framer

Interface
REQ-001 SHALL have parameter PREAMBLE_BYTES, default 4, number of 0xAA preamble bytes.
REQ-002 SHALL have parameter SYNC_WORD, default 16'hD391, 16-bit sync word sent MSB-first.
REQ-003 SHALL have parameter BIT_PERIOD, default 16, clk cycles per transmitted bit (>= 2*F0_HALF).
REQ-004 SHALL have parameter F0_HALF, default 4, tone half-period in clk cycles for bit 0.
REQ-005 SHALL have parameter F1_HALF, default 2, tone half-period in clk cycles for bit 1.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, frame start request, sampled when idle.
REQ-009 SHALL have port len, input, 8, payload byte count, sampled with start.
REQ-010 SHALL have port data_in, input, 8, payload byte.
REQ-011 SHALL have port data_valid, input, 1, data_in valid.
REQ-012 SHALL have port data_ready, output, 1, block can accept a payload byte.
REQ-013 SHALL have port busy, output, 1, frame in progress.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on successful frame end.
REQ-015 SHALL have port err, output, 1, one-cycle pulse on payload underrun abort.
REQ-016 SHALL have port antena_out, output, 1, FSK modulated line to the peer receiver.

Function
REQ-017 SHALL implement FSM states IDLE, PREAMBLE, SYNC, LEN, PAYLOAD, CRC, END.
REQ-018 Frame order SHALL be: PREAMBLE_BYTES x 0xAA, SYNC_WORD, len byte, len payload bytes, CRC byte; every field MSB-first.
REQ-019 CRC SHALL be CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over len byte and payload only.
REQ-020 start high in IDLE at edge N SHALL latch len, set busy at N+1 and begin first preamble bit at N+1; start while busy SHALL be ignored.
REQ-021 Each bit SHALL be held exactly BIT_PERIOD cycles; total frame SHALL last 8*(PREAMBLE_BYTES+4+len)*BIT_PERIOD cycles.
REQ-022 During a bit, antena_out SHALL toggle every F0_HALF cycles (bit 0) or F1_HALF cycles (bit 1); tone counter restarts at each bit boundary, antena_out level carries over (phase-continuous).
REQ-023 antena_out SHALL be 0 in IDLE and SHALL be forced to 0 on return to IDLE.
REQ-024 One-byte holding register: data_ready = busy & holding empty & bytes fetched < len; transfer on data_valid & data_ready same edge.
REQ-025 Fetching SHALL be permitted from the first cycle of PREAMBLE onward.
REQ-026 At each payload byte boundary the holding byte SHALL move to the shift register; if holding empty -> abort, err pulse 1 cycle, FSM to IDLE, busy low next cycle, no done.
REQ-027 len=0 SHALL skip PAYLOAD (CRC follows LEN) and data_ready SHALL stay 0 for that frame.
REQ-028 After the last CRC bit period, FSM SHALL pass through END: done=1 for exactly one cycle, busy low in that same cycle, IDLE next.
REQ-029 start asserted in the done cycle SHALL be ignored; a new frame starts from the IDLE cycle after.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, clear holding register, CRC, counters, and drive busy=0, done=0, err=0, data_ready=0, antena_out=0.
REQ-031 reset asserted mid-frame SHALL abort without done or err pulse; operation SHALL resume on first edge after reset release.

Verification (defaults)
REQ-032 start, len=0 -> busy for 1024 cycles, bits AA AA AA AA D3 91 00 00, done pulse once, data_ready never high.
REQ-033 start, len=1, data 0x01 supplied during preamble -> 1152-cycle frame, bytes ...D3 91 01 01 12, done pulse.
REQ-034 len=2, second byte withheld -> err pulse at the second payload byte boundary, busy low next cycle, antena_out=0, no done.
REQ-035 Bit 1 period: antena_out toggles every 2 cycles (8 toggles); bit 0 period toggles every 4 cycles (4 toggles); no phase reset at bit boundaries.
REQ-036 reset low during SYNC -> all outputs 0 immediately (async); new start after release gives a complete correct frame.
REQ-037 start pulses while busy and in done cycle -> ignored; exactly one frame transmitted.
